// File: rtl/idx_match_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the index match engine.
// Optional per-word match counting is enabled by defining IDX_MATCH_COUNT_EN.
package idx_match_pkg;

    localparam int DEF_N_WORDS    = 32;
    localparam int DEF_N_CH       = 8;
    localparam int DEF_DATA_W     = 5;
    localparam int DEF_MAX_CHUNKS = 8;

    localparam int DEF_POS_W = $clog2(DEF_N_CH * DEF_MAX_CHUNKS);
    localparam int DEF_CNT_W = $clog2(DEF_N_CH * DEF_MAX_CHUNKS) + 1;
    localparam int DEF_NC_W  = $clog2(DEF_MAX_CHUNKS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for single-input encoders.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idx_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is set and
// the index of the lowest set request.
module idx_prio_enc
    import idx_match_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        o_hit = |i_req;
        o_idx = '0;
        // Scan from the top down so the lowest set lane is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_req[k]) o_idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/index_match_engine.sv
// Searches streamed IA chunks for each of N_WORDS latched words and records the
// first matching position per word. Define IDX_MATCH_COUNT_EN to add o_count.
module index_match_engine
    import idx_match_pkg::*;
#(
    parameter int N_WORDS    = DEF_N_WORDS,
    parameter int N_CH       = DEF_N_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_CHUNKS = DEF_MAX_CHUNKS,
    parameter int POS_W      = $clog2(N_CH * MAX_CHUNKS)
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [$clog2(MAX_CHUNKS):0]        i_num_chunks,
    input  logic [N_WORDS-1:0][DATA_W-1:0]     i_word,
    input  logic                               i_ia_valid,
    output logic                               o_ia_ready,
    input  logic [N_CH-1:0][DATA_W-1:0]        i_ia,
    input  logic [N_CH-1:0]                    i_ia_mask,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [N_WORDS-1:0]                 o_valid,
    output logic [N_WORDS-1:0][POS_W-1:0]      o_pos
`ifdef IDX_MATCH_COUNT_EN
    ,
    output logic [N_WORDS-1:0][$clog2(N_CH*MAX_CHUNKS):0] o_count
`endif
);

    localparam int NC_W   = $clog2(MAX_CHUNKS) + 1;
    localparam int LANE_W = idx_w(N_CH);

    state_t                         r_state;
    state_t                         w_next_state;
    logic [N_WORDS-1:0][DATA_W-1:0] r_word;
    logic [NC_W-1:0]                r_num_chunks;
    logic [NC_W-1:0]                r_chunk;
    logic [NC_W-1:0]                w_num_clamped;
    logic [N_WORDS-1:0]             r_valid;
    logic [N_WORDS-1:0][POS_W-1:0]  r_pos;
    logic [N_WORDS-1:0][N_CH-1:0]   w_hits;
    logic [N_WORDS-1:0]             w_hit;
    logic [N_WORDS-1:0][LANE_W-1:0] w_lane;
    logic [N_WORDS-1:0][POS_W-1:0]  w_pos;
    logic                           w_start;
    logic                           w_accept;
    logic                           w_last;

    assign w_start  = (r_state == ST_IDLE) && i_start;
    assign w_accept = (r_state == ST_RUN) && i_ia_valid;
    assign w_last   = w_accept && (r_chunk == r_num_chunks - NC_W'(1));

    // A zero-length job still consumes one chunk; oversize requests are clamped.
    always_comb begin
        w_num_clamped = i_num_chunks;
        if (i_num_chunks == '0)
            w_num_clamped = NC_W'(1);
        else if (int'(i_num_chunks) > MAX_CHUNKS)
            w_num_clamped = NC_W'(MAX_CHUNKS);
    end

    for (genvar j = 0; j < N_WORDS; j++) begin : g_word
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            assign w_hits[j][k] = i_ia_mask[k] && (i_ia[k] == r_word[j]);
        end

        idx_prio_enc #(
            .N_CH  (N_CH),
            .IDX_W (LANE_W)
        ) u_enc (
            .i_req (w_hits[j]),
            .o_hit (w_hit[j]),
            .o_idx (w_lane[j])
        );

        assign w_pos[j] = POS_W'(int'(r_chunk) * N_CH + int'(w_lane[j]));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ia_ready = (r_state == ST_RUN);
        o_busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
        o_done     = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_word       <= '0;
            r_num_chunks <= '0;
            r_chunk      <= '0;
            r_valid      <= '0;
            r_pos        <= '0;
        end else if (w_start) begin
            r_word       <= i_word;
            r_num_chunks <= w_num_clamped;
            r_chunk      <= '0;
            r_valid      <= '0;
            r_pos        <= '0;
        end else if (w_accept) begin
            r_chunk <= r_chunk + NC_W'(1);
            // First match wins: a word already found keeps its position.
            for (int j = 0; j < N_WORDS; j++) begin
                if (!r_valid[j] && w_hit[j]) begin
                    r_valid[j] <= 1'b1;
                    r_pos[j]   <= w_pos[j];
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pos   = r_pos;

`ifdef IDX_MATCH_COUNT_EN
    localparam int CNT_W   = $clog2(N_CH * MAX_CHUNKS) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [N_WORDS-1:0][CNT_W-1:0] r_count;
    logic [N_WORDS-1:0][CNT_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        for (int j = 0; j < N_WORDS; j++) begin
            if (int'(r_count[j]) + $countones(w_hits[j]) > CNT_MAX)
                w_count_next[j] = '1;
            else
                w_count_next[j] = r_count[j] + CNT_W'($countones(w_hits[j]));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_count <= '0;
        else if (w_start)  r_count <= '0;
        else if (w_accept) r_count <= w_count_next;
    end

    assign o_count = r_count;
`endif

endmodule
